// File: rtl/ex_pkg.sv
// Shared encodings for the execute pipe: opcodes, shift types, flag positions,
// condition codes and opcode-class helpers.
package ex_pkg;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_EOR = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_RSB = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_ADC = 4'd5;
  localparam logic [3:0] OP_SBC = 4'd6;
  localparam logic [3:0] OP_RSC = 4'd7;
  localparam logic [3:0] OP_TST = 4'd8;
  localparam logic [3:0] OP_TEQ = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;
  localparam logic [3:0] OP_CMN = 4'd11;
  localparam logic [3:0] OP_ORR = 4'd12;
  localparam logic [3:0] OP_MOV = 4'd13;
  localparam logic [3:0] OP_BIC = 4'd14;
  localparam logic [3:0] OP_MVN = 4'd15;

  typedef enum logic [1:0] {
    SH_LSL = 2'd0,
    SH_LSR = 2'd1,
    SH_ASR = 2'd2,
    SH_ROR = 2'd3
  } shift_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  // TST/TEQ/CMP/CMN: always set flags, never write back.
  function automatic logic is_test(input logic [3:0] op);
    return (op[3:2] == 2'b10);
  endfunction

  function automatic logic is_arith(input logic [3:0] op);
    return ((op >= OP_SUB) && (op <= OP_RSC)) || (op == OP_CMP) || (op == OP_CMN);
  endfunction

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    n = f[FLAG_N];
    z = f[FLAG_Z];
    c = f[FLAG_C];
    v = f[FLAG_V];
    case (cond)
      COND_EQ: return z;
      COND_NE: return !z;
      COND_CS: return c;
      COND_CC: return !c;
      COND_MI: return n;
      COND_PL: return !n;
      COND_VS: return v;
      COND_VC: return !v;
      COND_HI: return c && !z;
      COND_LS: return !c || z;
      COND_GE: return n == v;
      COND_LT: return n != v;
      COND_GT: return !z && (n == v);
      COND_LE: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ex_pipe_unit_if.sv
// Op-in / result-out handshake bundle of the execute pipe, plus the NZCV view.
interface ex_pipe_unit_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
);
  localparam int SHAMT_W = $clog2(DATA_W);
  localparam int CTL_W   = SHAMT_W + 7;

  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic              in_s;
  logic              in_imm;
  logic [CTL_W-1:0]  in_ctl;
  logic [DATA_W-1:0] in_rn;
  logic [DATA_W-1:0] in_rm;
  logic [TAG_W-1:0]  in_tag;
  logic [3:0]        in_cond;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_wr_en;
  logic [TAG_W-1:0]  out_tag;
  logic [3:0]        flags;

  modport master (
    output in_valid, in_op, in_s, in_imm, in_ctl, in_rn, in_rm, in_tag, in_cond, out_ready,
    input  in_ready, out_valid, out_result, out_wr_en, out_tag, flags
  );

  modport slave (
    input  in_valid, in_op, in_s, in_imm, in_ctl, in_rn, in_rm, in_tag, in_cond, out_ready,
    output in_ready, out_valid, out_result, out_wr_en, out_tag, flags
  );

endinterface

// File: rtl/ex_operand_shifter.sv
// Operand-B generator: rotated immediate or shifted register, with shifter carry.
// RRX is flagged so the MSB can be filled with C when the ALU actually runs.
module ex_operand_shifter
  import ex_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]               i_rm,
  input  logic [$clog2(DATA_W)+6:0]       i_ctl,
  input  logic                            i_imm,
  output logic [DATA_W-1:0]               o_b,
  output logic                            o_sc,
  output logic                            o_sc_use_c,
  output logic                            o_is_rrx
);

  localparam int SHAMT_W = $clog2(DATA_W);
  localparam int CTL_W   = SHAMT_W + 7;

  function automatic logic [DATA_W-1:0] f_ror(input logic [DATA_W-1:0] x,
                                               input logic [SHAMT_W-1:0] a);
    return (x >> a) | (x << (DATA_W - int'(a)));
  endfunction

  logic [SHAMT_W-2:0] w_rot;
  logic [DATA_W-1:0]  w_imm8;
  logic [DATA_W-1:0]  w_imm_b;
  logic [SHAMT_W-1:0] w_shamt;
  shift_t             w_type;
  logic [DATA_W:0]    w_lsl;
  logic [DATA_W:0]    w_lsr;
  logic [DATA_W:0]    w_asr;
  logic [DATA_W-1:0]  w_ror;

  assign w_rot   = i_ctl[CTL_W-1:8];
  assign w_imm8  = {{(DATA_W-8){1'b0}}, i_ctl[7:0]};
  assign w_imm_b = f_ror(w_imm8, {w_rot, 1'b0});
  assign w_shamt = i_ctl[CTL_W-1:7];
  assign w_type  = shift_t'(i_ctl[6:5]);

  // One extra bit on each shift catches the last bit shifted out.
  assign w_lsl = {1'b0, i_rm} << w_shamt;
  assign w_lsr = {i_rm, 1'b0} >> w_shamt;
  assign w_asr = $signed({i_rm, 1'b0}) >>> w_shamt;
  assign w_ror = f_ror(i_rm, w_shamt);

  always_comb begin
    o_b        = '0;
    o_sc       = 1'b0;
    o_sc_use_c = 1'b0;
    o_is_rrx   = 1'b0;
    if (i_imm) begin
      o_b        = w_imm_b;
      o_sc       = w_imm_b[DATA_W-1];
      o_sc_use_c = (w_rot == '0);
    end else begin
      case (w_type)
        SH_LSL: begin
          o_b        = w_lsl[DATA_W-1:0];
          o_sc       = w_lsl[DATA_W];
          o_sc_use_c = (w_shamt == '0);
        end
        SH_LSR: begin
          if (w_shamt == '0) begin
            o_b  = '0;
            o_sc = i_rm[DATA_W-1];
          end else begin
            o_b  = w_lsr[DATA_W:1];
            o_sc = w_lsr[0];
          end
        end
        SH_ASR: begin
          if (w_shamt == '0) begin
            o_b  = {DATA_W{i_rm[DATA_W-1]}};
            o_sc = i_rm[DATA_W-1];
          end else begin
            o_b  = w_asr[DATA_W:1];
            o_sc = w_asr[0];
          end
        end
        SH_ROR: begin
          if (w_shamt == '0) begin
            o_b      = {1'b0, i_rm[DATA_W-1:1]};
            o_sc     = i_rm[0];
            o_is_rrx = 1'b1;
          end else begin
            o_b  = w_ror;
            o_sc = w_ror[DATA_W-1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ex_pipe_unit.sv
// Two-stage execute pipe: S1 holds the shifted operand, the ALU result and NZCV
// are registered on the S1->S2 transfer. Optional EX_COND_EN adds condition gating.
module ex_pipe_unit
  import ex_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic          clk,
  input  logic          reset,
  ex_pipe_unit_if.slave bus
);

  logic [DATA_W-1:0] w_sh_b;
  logic              w_sh_sc;
  logic              w_sh_use_c;
  logic              w_sh_rrx;

  ex_operand_shifter #(.DATA_W(DATA_W)) u_shifter (
    .i_rm       (bus.in_rm),
    .i_ctl      (bus.in_ctl),
    .i_imm      (bus.in_imm),
    .o_b        (w_sh_b),
    .o_sc       (w_sh_sc),
    .o_sc_use_c (w_sh_use_c),
    .o_is_rrx   (w_sh_rrx)
  );

  logic              r_s1_valid;
  logic [3:0]        r_s1_op;
  logic              r_s1_s;
  logic [DATA_W-1:0] r_s1_a;
  logic [DATA_W-1:0] r_s1_b;
  logic              r_s1_sc;
  logic              r_s1_sc_use_c;
  logic              r_s1_rrx;
  logic [TAG_W-1:0]  r_s1_tag;
`ifdef EX_COND_EN
  logic [3:0]        r_s1_cond;
`endif

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_result;
  logic              r_out_wr_en;
  logic [TAG_W-1:0]  r_out_tag;
  logic [3:0]        r_flags;

  logic w_advance2, w_in_ready, w_accept, w_xfer;

  assign w_advance2 = ~r_out_valid | bus.out_ready;
  assign w_in_ready = ~r_s1_valid | w_advance2;
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_xfer     = r_s1_valid & w_advance2;

  // Flag-dependent inputs read the live register, so a back-to-back op sees
  // the flags its predecessor wrote at the same edge it entered S1.
  logic              w_c_in;
  logic [DATA_W-1:0] w_b;
  logic              w_shc;
  logic [DATA_W-1:0] w_x, w_y;
  logic              w_cin;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_logic;
  logic              w_arith;
  logic [DATA_W-1:0] w_res;
  logic              w_n, w_z, w_c, w_v;
  logic              w_cond_ok;
  logic              w_set_flags;
  logic              w_wr_en;

  assign w_c_in = r_flags[FLAG_C];
  assign w_b    = r_s1_rrx ? {w_c_in, r_s1_b[DATA_W-2:0]} : r_s1_b;
  assign w_shc  = r_s1_sc_use_c ? w_c_in : r_s1_sc;

  always_comb begin
    w_x   = r_s1_a;
    w_y   = w_b;
    w_cin = 1'b0;
    case (r_s1_op)
      OP_SUB, OP_CMP: begin w_x = r_s1_a; w_y = ~w_b;    w_cin = 1'b1;   end
      OP_RSB:         begin w_x = w_b;    w_y = ~r_s1_a; w_cin = 1'b1;   end
      OP_ADD, OP_CMN: begin w_x = r_s1_a; w_y = w_b;     w_cin = 1'b0;   end
      OP_ADC:         begin w_x = r_s1_a; w_y = w_b;     w_cin = w_c_in; end
      OP_SBC:         begin w_x = r_s1_a; w_y = ~w_b;    w_cin = w_c_in; end
      OP_RSC:         begin w_x = w_b;    w_y = ~r_s1_a; w_cin = w_c_in; end
      default: ;
    endcase
  end

  assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {{DATA_W{1'b0}}, w_cin};

  always_comb begin
    w_logic = '0;
    case (r_s1_op)
      OP_AND, OP_TST: w_logic = r_s1_a & w_b;
      OP_EOR, OP_TEQ: w_logic = r_s1_a ^ w_b;
      OP_ORR:         w_logic = r_s1_a | w_b;
      OP_MOV:         w_logic = w_b;
      OP_BIC:         w_logic = r_s1_a & ~w_b;
      OP_MVN:         w_logic = ~w_b;
      default: ;
    endcase
  end

  assign w_arith = is_arith(r_s1_op);
  assign w_res   = w_arith ? w_sum[DATA_W-1:0] : w_logic;
  assign w_n     = w_res[DATA_W-1];
  assign w_z     = (w_res == '0);
  assign w_c     = w_arith ? w_sum[DATA_W] : w_shc;
  assign w_v     = w_arith ? ((w_x[DATA_W-1] == w_y[DATA_W-1]) &&
                              (w_sum[DATA_W-1] != w_x[DATA_W-1]))
                           : r_flags[FLAG_V];

`ifdef EX_COND_EN
  assign w_cond_ok = cond_pass(r_s1_cond, r_flags);
`else
  assign w_cond_ok = 1'b1;
`endif

  assign w_set_flags = (r_s1_s | is_test(r_s1_op)) & w_cond_ok;
  assign w_wr_en     = ~is_test(r_s1_op) & w_cond_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid    <= 1'b0;
      r_s1_op       <= '0;
      r_s1_s        <= 1'b0;
      r_s1_a        <= '0;
      r_s1_b        <= '0;
      r_s1_sc       <= 1'b0;
      r_s1_sc_use_c <= 1'b0;
      r_s1_rrx      <= 1'b0;
      r_s1_tag      <= '0;
`ifdef EX_COND_EN
      r_s1_cond     <= COND_AL;
`endif
      r_out_valid   <= 1'b0;
      r_out_result  <= '0;
      r_out_wr_en   <= 1'b0;
      r_out_tag     <= '0;
      r_flags       <= '0;
    end else begin
      if (w_in_ready) r_s1_valid <= bus.in_valid;
      if (w_accept) begin
        r_s1_op       <= bus.in_op;
        r_s1_s        <= bus.in_s;
        r_s1_a        <= bus.in_rn;
        r_s1_b        <= w_sh_b;
        r_s1_sc       <= w_sh_sc;
        r_s1_sc_use_c <= w_sh_use_c;
        r_s1_rrx      <= w_sh_rrx;
        r_s1_tag      <= bus.in_tag;
`ifdef EX_COND_EN
        r_s1_cond     <= bus.in_cond;
`endif
      end
      if (w_advance2) r_out_valid <= r_s1_valid;
      if (w_xfer) begin
        r_out_result <= w_res;
        r_out_wr_en  <= w_wr_en;
        r_out_tag    <= r_s1_tag;
        if (w_set_flags) r_flags <= {w_n, w_z, w_c, w_v};
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_result = r_out_result;
  assign bus.out_wr_en  = r_out_wr_en;
  assign bus.out_tag    = r_out_tag;
  assign bus.flags      = r_flags;

endmodule
